// File: rtl/shift_sub_divider_if.sv
// Request/result bundle for shift_sub_divider: operands and start in, quotient,
// remainder and status out.
interface shift_sub_divider_if #(parameter int N = 8);
   logic             start;
   logic [N-1:0]     dividend;
   logic [N/2-1:0]   divisor;
   logic [N/2-1:0]   quotient;
   logic [N/2-1:0]   remainder;
   logic             busy;
   logic             done;
   logic             ovf;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, ovf
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, ovf
   );
endinterface

// File: rtl/shift_sub_divider.sv
// Restoring shift/subtract divider: N-bit dividend / (N/2)-bit divisor, one quotient bit per cycle.
// Define SHIFT_SUB_DIVIDER_OVF_DETECT_EN to add the CHECK state and the ovf flag.
module shift_sub_divider #(
   parameter int N = 8
) (
   input logic                clk,
   input logic                rst,
   shift_sub_divider_if.slave bus
);
   localparam int HW = N / 2;
   localparam int CW = $clog2(HW) + 1;
   localparam logic [CW-1:0] LAST = CW'(HW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
`ifdef SHIFT_SUB_DIVIDER_OVF_DETECT_EN
      CHECK = 2'd1,
`endif
      CALC  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t st, nxt;

   // A is only HW bits wide here: its top bit is zero after every load and every
   // accepted subtraction, so it never needs storage.
   logic [HW-1:0] a;
   logic [HW-1:0] q;
   logic [HW-1:0] d;
   logic [CW-1:0] cnt;
   logic [HW:0]   t;
   logic [HW:0]   dx;
   logic          busy_c;
   logic          done_c;

   assign t  = {a, q[HW-1]};
   assign dx = {1'b0, d};

`ifdef SHIFT_SUB_DIVIDER_OVF_DETECT_EN
   logic ovf_r;
   logic ovf_hit;
   // a still holds the dividend's upper half while in CHECK
   assign ovf_hit = (d == '0) || (a >= d);
   assign bus.ovf = ovf_r;
`else
   assign bus.ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) st <= IDLE;
      else     st <= nxt;
   end

   always_comb begin
      nxt    = st;
      busy_c = 1'b1;
      done_c = 1'b0;
      case (st)
         IDLE: begin
            busy_c = 1'b0;
`ifdef SHIFT_SUB_DIVIDER_OVF_DETECT_EN
            if (bus.start) nxt = CHECK;
`else
            if (bus.start) nxt = CALC;
`endif
         end
`ifdef SHIFT_SUB_DIVIDER_OVF_DETECT_EN
         CHECK: nxt = ovf_hit ? DONE : CALC;
`endif
         CALC:  if (cnt == LAST) nxt = DONE;
         DONE: begin
            done_c = 1'b1;
            nxt    = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a   <= '0;
         q   <= '0;
         d   <= '0;
         cnt <= '0;
`ifdef SHIFT_SUB_DIVIDER_OVF_DETECT_EN
         ovf_r <= 1'b0;
`endif
      end else begin
         case (st)
            IDLE: if (bus.start) begin
               a   <= bus.dividend[N-1:HW];
               q   <= bus.dividend[HW-1:0];
               d   <= bus.divisor;
               cnt <= '0;
`ifdef SHIFT_SUB_DIVIDER_OVF_DETECT_EN
               ovf_r <= 1'b0;
`endif
            end
`ifdef SHIFT_SUB_DIVIDER_OVF_DETECT_EN
            CHECK: begin
               ovf_r <= ovf_hit;
               cnt   <= '0;
            end
`endif
            CALC: begin
               if (t >= dx) begin
                  a <= HW'(t - dx);
                  q <= {q[HW-2:0], 1'b1};
               end else begin
                  a <= t[HW-1:0];
                  q <= {q[HW-2:0], 1'b0};
               end
               cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient  = q;
   assign bus.remainder = a;
   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
endmodule
